boid_frame_painter: RTL and testbench

- Upstream neighbour of the VGA display controller.
- Owns a double-buffered 1-bit boid bitmap (WIDTH x HEIGHT) and repaints the back bank once per frame from the boid position memory.
- Serves the controller's pixel read port from the front bank.
- Swaps banks on the controller's screenEnd, so the display never shows a half-painted frame.

---
 rtl/boid_frame_painter.sv | 243 ++++++++++++++++++++++++
 tb/tb_boid_frame_painter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/boid_frame_painter.sv
// boid_frame_painter
// Double-buffered 1-bit boid bitmap. Once per frame the painter clears the back
// bank and plots a BOID_SIZE x BOID_SIZE square for every boid that it reads
// from the position memory. The display controller reads the front bank. The banks
// swap on a screenEnd rising edge, and only after the back bank is complete.
// Optional build macro: PAINTER_OVERRUN_COUNT_EN adds an 8-bit saturating
// counter of triggers that arrive while the painter is still busy.
module boid_frame_painter #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int ADDR_WIDTH = 20,
    parameter int NUM_BOIDS  = 16,
    parameter int BOID_SIZE  = 2,
    parameter int IDX_W      = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  screenEnd,
    input  logic [ADDR_WIDTH-1:0] read_address,
    output logic                  read_data,
    output logic [IDX_W-1:0]      pos_index,
    input  logic [9:0]            pos_x,
    input  logic [8:0]            pos_y,
    output logic                  busy,
    output logic                  frame_ready,
    output logic                  front_bank
`ifdef PAINTER_OVERRUN_COUNT_EN
    ,
    output logic [7:0]            overrun_count
`endif
);

    localparam int NPIX   = WIDTH * HEIGHT;
    localparam int PIX_AW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [ADDR_WIDTH-1:0] NPIX_A   = ADDR_WIDTH'(NPIX);
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(NPIX - 1);
    localparam logic [ADDR_WIDTH-1:0] WIDTH_A  = ADDR_WIDTH'(WIDTH);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_BOIDS - 1);
    localparam logic [1:0]            D_LAST   = 2'(BOID_SIZE - 1);
    localparam logic [10:0]           X_LIM    = 11'(WIDTH);
    localparam logic [9:0]            Y_LIM    = 10'(HEIGHT);

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_PLOT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [ADDR_WIDTH-1:0]   clr_cnt_r;
    logic [IDX_W-1:0]        idx_r;
    logic [9:0]              px_r;
    logic [8:0]              py_r;
    logic [1:0]              dx_r, dy_r;
    logic                    front_bank_r, blank_r, se_d_r;
    logic                    busy_r, frame_ready_r, read_data_r;

    logic                    trigger_s, swap_s, plot_last_s, plot_in_s, rd_bit_s;
    logic                    wr_en_s, wr_data_s;
    logic [ADDR_WIDTH-1:0]   wr_addr_s, plot_addr_s;
    logic [10:0]             x_sum_s;
    logic [9:0]              y_sum_s;

    logic bank0_r [0:NPIX-1];
    logic bank1_r [0:NPIX-1];

    assign trigger_s   = screenEnd & ~se_d_r;
    assign x_sum_s     = 11'(px_r) + 11'(dx_r);
    assign y_sum_s     = 10'(py_r) + 10'(dy_r);
    assign plot_in_s   = (x_sum_s < X_LIM) && (y_sum_s < Y_LIM);
    assign plot_addr_s = ADDR_WIDTH'(x_sum_s) + WIDTH_A * ADDR_WIDTH'(y_sum_s);
    assign plot_last_s = (dx_r == D_LAST) && (dy_r == D_LAST);

    assign read_data   = read_data_r;
    assign pos_index   = idx_r;
    assign busy        = busy_r;
    assign frame_ready = frame_ready_r;
    assign front_bank  = front_bank_r;

    // Next-state decode and back-bank write request
    always_comb begin
        state_nxt_s = state_r;
        wr_en_s     = 1'b0;
        wr_data_s   = 1'b0;
        wr_addr_s   = clr_cnt_r;
        swap_s      = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                wr_en_s = 1'b1;
                if (clr_cnt_r == CLR_LAST) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_FETCH: state_nxt_s = ST_WAIT;
            ST_WAIT:  state_nxt_s = ST_PLOT;
            ST_PLOT: begin
                // Off-screen pixels still take their cycle but never write
                wr_en_s   = plot_in_s;
                wr_data_s = 1'b1;
                wr_addr_s = plot_addr_s;
                if (plot_last_s) begin
                    if (idx_r == IDX_LAST) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end else begin
                    state_nxt_s = ST_PLOT;
                end
            end
            ST_DONE: begin
                if (trigger_s) begin
                    swap_s      = 1'b1;
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_CLEAR;
        endcase
    end

    // Front-bank read mux; blank hides both banks until the first swap
    always_comb begin
        rd_bit_s = 1'b0;
        if (blank_r) begin
            rd_bit_s = 1'b0;
        end else if (read_address >= NPIX_A) begin
            rd_bit_s = 1'b0;
        end else if (front_bank_r) begin
            rd_bit_s = bank1_r[read_address[PIX_AW-1:0]];
        end else begin
            rd_bit_s = bank0_r[read_address[PIX_AW-1:0]];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Painter counters, bank control and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt_r     <= '0;
            idx_r         <= '0;
            px_r          <= 10'd0;
            py_r          <= 9'd0;
            dx_r          <= 2'd0;
            dy_r          <= 2'd0;
            front_bank_r  <= 1'b0;
            blank_r       <= 1'b1;
            se_d_r        <= 1'b0;
            busy_r        <= 1'b1;
            frame_ready_r <= 1'b0;
            read_data_r   <= 1'b0;
        end else begin
            se_d_r        <= screenEnd;
            busy_r        <= (state_nxt_s != ST_DONE);
            frame_ready_r <= (state_nxt_s == ST_DONE);
            read_data_r   <= rd_bit_s;
            case (state_r)
                ST_CLEAR: begin
                    if (clr_cnt_r == CLR_LAST) begin
                        clr_cnt_r <= '0;
                        idx_r     <= '0;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + ADDR_WIDTH'(1);
                    end
                end
                ST_FETCH: begin
                end
                ST_WAIT: begin
                    px_r <= pos_x;
                    py_r <= pos_y;
                    dx_r <= 2'd0;
                    dy_r <= 2'd0;
                end
                ST_PLOT: begin
                    if (dx_r == D_LAST) begin
                        dx_r <= 2'd0;
                        if (dy_r == D_LAST) begin
                            dy_r  <= 2'd0;
                            idx_r <= idx_r + IDX_W'(1);
                        end else begin
                            dy_r <= dy_r + 2'd1;
                        end
                    end else begin
                        dx_r <= dx_r + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (swap_s) begin
                        front_bank_r <= ~front_bank_r;
                        blank_r      <= 1'b0;
                        clr_cnt_r    <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bitmap write port: only the back bank is ever written, contents are not reset
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            if (front_bank_r) begin
                bank0_r[wr_addr_s[PIX_AW-1:0]] <= wr_data_s;
            end else begin
                bank1_r[wr_addr_s[PIX_AW-1:0]] <= wr_data_s;
            end
        end
    end

`ifdef PAINTER_OVERRUN_COUNT_EN
    logic [7:0] overrun_cnt_r;
    logic       overrun_s;

    assign overrun_s     = trigger_s && (state_r != ST_DONE);
    assign overrun_count = overrun_cnt_r;

    // Saturating count of frame triggers that arrived before painting finished
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_cnt_r <= 8'd0;
        end else if (overrun_s && (overrun_cnt_r != 8'hFF)) begin
            overrun_cnt_r <= overrun_cnt_r + 8'd1;
        end
    end
`else
    // Without the counter an overrun trigger is simply ignored by the FSM.
`endif

endmodule

// File: tb/tb_boid_frame_painter.sv
// Self-checking bench for boid_frame_painter on an 8x4 screen with two 2x2 boids
// at (1,1) and (7,3). Painted image: addresses 9,10,17,18,31 (7,3 is clipped).
module tb_boid_frame_painter;

    localparam int W = 8, H = 4, AW = 20, NB = 2, BS = 2, IW = 1;

    logic          clk = 1'b0;
    logic          reset, screenEnd;
    logic [AW-1:0] read_address;
    logic          read_data;
    logic [IW-1:0] pos_index;
    logic [9:0]    pos_x;
    logic [8:0]    pos_y;
    logic          busy, frame_ready, front_bank;
`ifdef PAINTER_OVERRUN_COUNT_EN
    logic [7:0]    overrun_count;
`endif

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic          exp;
    } vec_t;
    vec_t tbl [36];

    boid_frame_painter #(
        .WIDTH(W), .HEIGHT(H), .ADDR_WIDTH(AW), .NUM_BOIDS(NB), .BOID_SIZE(BS)
    ) dut (
        .clk(clk), .reset(reset), .screenEnd(screenEnd),
        .read_address(read_address), .read_data(read_data),
        .pos_index(pos_index), .pos_x(pos_x), .pos_y(pos_y),
        .busy(busy), .frame_ready(frame_ready), .front_bank(front_bank)
`ifdef PAINTER_OVERRUN_COUNT_EN
        , .overrun_count(overrun_count)
`endif
    );

    always #5 clk = ~clk;

    // Position memory model: synchronous read, one clock of latency
    always @(posedge clk) begin
        pos_x <= (pos_index == 1'b0) ? 10'd1 : 10'd7;
        pos_y <= (pos_index == 1'b0) ? 9'd1  : 9'd3;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Run until frame_ready (bounded); optionally pulse screenEnd starting at edge se_at
    task automatic run_frame(input int se_at, output int n, output int nz, output int bb);
        n = 0; nz = 0; bb = 0;
        while (n < 300) begin
            @(posedge clk); #1;
            n++;
            if (n == se_at) screenEnd = 1'b1;
            if (n == se_at + 3) screenEnd = 1'b0;
            if (read_data !== 1'b0) nz++;
            if (frame_ready === 1'b1) break;
            if (busy !== 1'b1) bb++;
            read_address = AW'(n % 32);
        end
    endtask

    // Stream the table through the read port, one address per clock
    task automatic read_table(input string tag);
        for (int i = 0; i <= 36; i++) begin
            @(negedge clk);
            if (i > 0) chk($sformatf("%s_rd%0d", tag, tbl[i-1].addr), int'(read_data), int'(tbl[i-1].exp));
            if (i < 36) read_address = tbl[i].addr;
        end
    endtask

    initial begin
        int n, nz, bb;
        for (int a = 0; a < 32; a++) begin
            tbl[a].addr = AW'(a);
            tbl[a].exp  = 1'b0;
        end
        tbl[9].exp  = 1'b1;
        tbl[10].exp = 1'b1;
        tbl[17].exp = 1'b1;
        tbl[18].exp = 1'b1;
        tbl[31].exp = 1'b1;
        tbl[32] = '{addr: 20'd41,   exp: 1'b0};
        tbl[33] = '{addr: 20'd42,   exp: 1'b0};
        tbl[34] = '{addr: 20'd63,   exp: 1'b0};
        tbl[35] = '{addr: 20'd1033, exp: 1'b0};

        // Reset state
        reset = 1'b1; screenEnd = 1'b0; read_address = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_ready", frame_ready, 0);
        chk("rst_front", front_bank, 0);
        chk("rst_rdata", read_data, 0);
        chk("rst_pidx", pos_index, 0);

        // First frame: 44 busy clocks, read port blank throughout
        @(negedge clk); reset = 1'b0;
        run_frame(-1, n, nz, bb);
        chk("f1_len", n, 44);
        chk("f1_busy", bb, 0);
        chk("f1_blank", nz, 0);
        chk("f1_done_busy", busy, 0);
        nz = 0;
        for (int a = 0; a < 32; a++) begin
            @(negedge clk); read_address = AW'(a);
            @(negedge clk); if (read_data !== 1'b0) nz++;
        end
        chk("done_blank", nz, 0);

        // Swap; screenEnd stays high through the next DONE and must not retrigger
        @(negedge clk); screenEnd = 1'b1;
        @(posedge clk); #1;
        chk("sw1_front", front_bank, 1);
        chk("sw1_busy", busy, 1);
        chk("sw1_ready", frame_ready, 0);
        repeat (50) @(posedge clk);
        #1;
        chk("held_front", front_bank, 1);
        chk("held_ready", frame_ready, 1);
        @(negedge clk); screenEnd = 1'b0;
        read_table("b1");

        // Second swap shows bank 0, painted during the previous frame
        @(negedge clk); screenEnd = 1'b1;
        @(posedge clk); #1;
        chk("sw2_front", front_bank, 0);
        screenEnd = 1'b0;
        run_frame(-1, n, nz, bb);
        chk("f3_len", n, 44);
        read_table("b0");

        // Overrun: trigger 10 clocks into painting
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        run_frame(10, n, nz, bb);
        chk("ov_len", n, 44);
        chk("ov_front", front_bank, 0);
`ifdef PAINTER_OVERRUN_COUNT_EN
        chk("ov_count", overrun_count, 1);
`endif
        @(negedge clk); screenEnd = 1'b1;
        @(posedge clk); #1;
        chk("ov_swap", front_bank, 1);
        screenEnd = 1'b0;

        // Trigger on the clock the last PLOT finishes: DONE, no swap
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        run_frame(43, n, nz, bb);
        chk("edge_len", n, 44);
        chk("edge_front", front_bank, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("edge_hold_front", front_bank, 0);
`ifdef PAINTER_OVERRUN_COUNT_EN
        chk("edge_count", overrun_count, 1);
`endif
        @(negedge clk); screenEnd = 1'b0;
        @(negedge clk); screenEnd = 1'b1;
        @(posedge clk); #1;
        chk("edge_swap", front_bank, 1);
        screenEnd = 1'b0;
        read_address = AW'(9);

        // Reset in the middle of PLOT
        repeat (35) @(posedge clk);
        #1;
        chk("mid_rdata", read_data, 1);
        chk("mid_busy", busy, 1);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("mr_busy", busy, 1);
        chk("mr_front", front_bank, 0);
        chk("mr_rdata", read_data, 0);
        chk("mr_ready", frame_ready, 0);
        chk("mr_pidx", pos_index, 0);
        @(negedge clk); reset = 1'b0;
        run_frame(-1, n, nz, bb);
        chk("mr_len", n, 44);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
